// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell; the bit-slice of the serial adder.
// Latency: combinational, zero cycles.
// Backpressure: none, pure logic.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: {cout, sum} = a + b + cin, one bit per clock, LSB first.
// Latency: out_valid rises WIDTH edges after the accept edge; one op per WIDTH+2 cycles.
// Backpressure: holds sum/cout/out_valid in DONE until out_ready; in_ready only in IDLE.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             last;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  // Holds only the WIDTH-1 already-computed sum bits; the final bit comes
  // straight from the adder on the RUN -> DONE edge.
  logic [WIDTH-2:0] s_sh;
  logic [WIDTH-2:0] s_shift;
  logic             carry;
  logic [CNT_W-1:0] count;

  logic             fa_sum;
  logic             fa_cout;

  full_adder u_bit_slice (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Next partial-sum register: shift right, new bit enters at the top.
  always_comb begin
    s_shift           = s_sh >> 1;
    s_shift[WIDTH-2]  = fa_sum;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode plus handshake outputs derived from state.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (count == CNT_W'(WIDTH - 1)) begin
          last      = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    busy = !in_ready;
  end

  // Operand load, bit-serial shift/add, and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh      <= '0;
      b_sh      <= '0;
      s_sh      <= '0;
      carry     <= 1'b0;
      count     <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        a_sh  <= a;
        b_sh  <= b;
        carry <= cin;
        count <= '0;
      end
      if (state == ST_RUN) begin
        a_sh  <= a_sh >> 1;
        b_sh  <= b_sh >> 1;
        s_sh  <= s_shift;
        carry <= fa_cout;
        count <= count + CNT_W'(1);
        if (last) begin
          sum       <= {fa_sum, s_sh};
          cout      <= fa_cout;
          out_valid <= 1'b1;
        end
      end
      if (state == ST_DONE && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
